// File: rtl/mem_wb_sram_stage.sv
// ARM memory stage: 32-bit loads/stores over a 16-bit async SRAM, feeding MEM/WB.
// Optional single-entry load buffer is enabled with READ_BUFFER_EN.
module mem_wb_sram_stage #(
    parameter int WORD_LENGTH   = 32,
    parameter int REG_ADDR_LEN  = 4,
    parameter int SRAM_ADDR_LEN = 18,
    parameter int WAIT_CYCLES   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read_in,
    input  logic                     mem_write_in,
    input  logic                     wb_enable_in,
    input  logic [REG_ADDR_LEN-1:0]  wb_dest_in,
    input  logic [WORD_LENGTH-1:0]   alu_result_in,
    input  logic [WORD_LENGTH-1:0]   store_value,
    output logic                     freeze,
    output logic                     mem_read_out,
    output logic                     wb_enable_out,
    output logic [REG_ADDR_LEN-1:0]  wb_dest_out,
    output logic [WORD_LENGTH-1:0]   alu_result_out,
    output logic [WORD_LENGTH-1:0]   data_memory_out,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    inout  wire  [15:0]              sram_dq,
    output logic                     sram_we_n,
    output logic                     sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int WA = SRAM_ADDR_LEN - 1;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [15:0]             lo_q, lo_d, hi_q, hi_d;
    logic                    mrd_q, mrd_d, wbe_q, wbe_d;
    logic [REG_ADDR_LEN-1:0] dest_q, dest_d;
    logic [WORD_LENGTH-1:0]  alu_q, alu_d, data_q, data_d;

    logic [WORD_LENGTH-1:0]  ea;
    logic [WA-1:0]           waddr;
    logic                    is_wr, is_rd, hit, req, last, active, half;
    logic [WORD_LENGTH-1:0]  hit_data;
    logic                    unused_ok;

    assign ea        = alu_result_in - WORD_LENGTH'(1024);
    assign waddr     = ea[SRAM_ADDR_LEN:2];
    assign unused_ok = ^{ea[1:0], ea[WORD_LENGTH-1:SRAM_ADDR_LEN+1]};

    // A simultaneous read and write is resolved as a write.
    assign is_wr  = mem_write_in;
    assign is_rd  = mem_read_in & ~mem_write_in;
    assign req    = (is_rd & ~hit) | is_wr;
    assign last   = (cnt_q == CW'(WAIT_CYCLES - 1));
    assign active = (state_q == LO) | (state_q == HI);
    assign half   = (state_q == HI);

    assign freeze = ~rst & (active | ((state_q == IDLE) & req));

`ifdef READ_BUFFER_EN
    logic                   buf_vld_q, buf_vld_d;
    logic [WA-1:0]          buf_addr_q, buf_addr_d;
    logic [WORD_LENGTH-1:0] buf_data_q, buf_data_d;
    logic                   buf_match;

    assign buf_match = buf_vld_q & (buf_addr_q == waddr);
    assign hit       = is_rd & buf_match & (state_q == IDLE);
    assign hit_data  = buf_data_q;

    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        if (state_q == DONE) begin
            if (is_rd) begin
                buf_vld_d  = 1'b1;
                buf_addr_d = waddr;
                buf_data_d = WORD_LENGTH'({hi_q, lo_q});
            end else if (is_wr && buf_match) begin
                buf_data_d = store_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        unique case (state_q)
            IDLE: if (req) begin
                state_d = LO;
                cnt_d   = '0;
            end
            LO: if (last) begin
                state_d = HI;
                cnt_d   = '0;
                if (is_rd) lo_d = sram_dq;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            HI: if (last) begin
                state_d = DONE;
                cnt_d   = '0;
                if (is_rd) hi_d = sram_dq;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // MEM/WB: bubble while frozen, load on a free IDLE cycle or in DONE.
    always_comb begin
        mrd_d  = mrd_q;
        wbe_d  = wbe_q;
        dest_d = dest_q;
        alu_d  = alu_q;
        data_d = data_q;
        if (freeze) begin
            mrd_d = 1'b0;
            wbe_d = 1'b0;
        end else if ((state_q == IDLE) || (state_q == DONE)) begin
            mrd_d  = is_rd;
            wbe_d  = wb_enable_in;
            dest_d = wb_dest_in;
            alu_d  = alu_result_in;
            if ((state_q == DONE) && is_rd) data_d = WORD_LENGTH'({hi_q, lo_q});
            if (hit) data_d = hit_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            mrd_q   <= 1'b0;
            wbe_q   <= 1'b0;
            dest_q  <= '0;
            alu_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            mrd_q   <= mrd_d;
            wbe_q   <= wbe_d;
            dest_q  <= dest_d;
            alu_q   <= alu_d;
            data_q  <= data_d;
        end
    end

    assign sram_addr = active ? {waddr, half} : '0;
    assign sram_we_n = ~(active & is_wr);
    assign sram_oe_n = ~(active & is_rd);
    assign sram_dq   = (active & is_wr) ?
                       (half ? store_value[31:16] : store_value[15:0]) : 16'hzzzz;

    assign mem_read_out    = mrd_q;
    assign wb_enable_out   = wbe_q;
    assign wb_dest_out     = dest_q;
    assign alu_result_out  = alu_q;
    assign data_memory_out = data_q;

endmodule

// File: tb/tb_mem_wb_sram_stage.sv
// Directed bench for mem_wb_sram_stage with a behavioural async SRAM model.
module tb_mem_wb_sram_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_in, mem_write_in, wb_enable_in;
    logic [3:0]  wb_dest_in;
    logic [31:0] alu_result_in, store_value;
    logic        freeze, mem_read_out, wb_enable_out;
    logic [3:0]  wb_dest_out;
    logic [31:0] alu_result_out, data_memory_out;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n, sram_oe_n;

    mem_wb_sram_stage dut (
        .clk(clk), .rst(rst),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .wb_enable_in(wb_enable_in), .wb_dest_in(wb_dest_in),
        .alu_result_in(alu_result_in), .store_value(store_value),
        .freeze(freeze), .mem_read_out(mem_read_out),
        .wb_enable_out(wb_enable_out), .wb_dest_out(wb_dest_out),
        .alu_result_out(alu_result_out), .data_memory_out(data_memory_out),
        .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:1023];
    int          oe_cnt = 0;

    assign sram_dq = !sram_oe_n ? mem[sram_addr[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[9:0]] <= sram_dq;
        if (!sram_oe_n) oe_cnt <= oe_cnt + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [17:0] addr_log [64];
    logic [15:0] dq_log   [64];
    logic        we_log   [64];
    logic        wbe_log  [64];

    task automatic idle_inputs();
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        wb_enable_in  = 1'b0;
        wb_dest_in    = '0;
        alu_result_in = '0;
        store_value   = '0;
    endtask

    task automatic mem_op(input logic rd, input logic wr, input logic wbe,
                          input logic [3:0] dest, input logic [31:0] alu,
                          input logic [31:0] sv, output int fc);
        @(posedge clk); #1;
        mem_read_in   = rd;
        mem_write_in  = wr;
        wb_enable_in  = wbe;
        wb_dest_in    = dest;
        alu_result_in = alu;
        store_value   = sv;
        fc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!freeze) break;
            if (fc < 64) begin
                addr_log[fc] = sram_addr;
                dq_log[fc]   = sram_dq;
                we_log[fc]   = sram_we_n;
                wbe_log[fc]  = wb_enable_out;
            end
            fc++;
        end
        chk("op_completes", {31'b0, freeze}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
    endtask

    typedef struct {
        logic        wbe;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic        exp_wbe;
        logic [3:0]  exp_dest;
        logic [31:0] exp_alu;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int fc, errs, oe0;

        vecs[0] = '{1'b1, 4'd3,  32'h0000_0055, 1'b1, 4'd3,  32'h0000_0055};
        vecs[1] = '{1'b0, 4'd9,  32'hFFFF_FFFF, 1'b0, 4'd9,  32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 4'd15, 32'h0000_0400, 1'b1, 4'd15, 32'h0000_0400};
        vecs[3] = '{1'b1, 4'd0,  32'h0000_0000, 1'b1, 4'd0,  32'h0000_0000};

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_freeze", {31'b0, freeze}, 32'd0);
        chk("rst_we_n",   {31'b0, sram_we_n}, 32'd1);
        chk("rst_oe_n",   {31'b0, sram_oe_n}, 32'd1);
        chk("rst_addr",   {14'b0, sram_addr}, 32'd0);
        chk("rst_wbe",    {31'b0, wb_enable_out}, 32'd0);
        chk("rst_data",   data_memory_out, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            @(posedge clk); #1;
            wb_enable_in  = vecs[v].wbe;
            wb_dest_in    = vecs[v].dest;
            alu_result_in = vecs[v].alu;
            @(negedge clk);
            chk("alu_freeze", {31'b0, freeze}, 32'd0);
            @(negedge clk);
            chk("alu_wbe",  {31'b0, wb_enable_out}, {31'b0, vecs[v].exp_wbe});
            chk("alu_dest", {28'b0, wb_dest_out}, {28'b0, vecs[v].exp_dest});
            chk("alu_res",  alu_result_out, vecs[v].exp_alu);
            chk("alu_mrd",  {31'b0, mem_read_out}, 32'd0);
        end

        mem_op(1'b0, 1'b1, 1'b1, 4'd5, 32'd1028, 32'hDEAD_BEEF, fc);
        chk("st_freeze_cycles", fc, 32'd11);
        errs = 0;
        if (fc >= 11) begin
            if (we_log[0] !== 1'b1) errs++;
            for (int i = 1; i <= 10; i++) begin
                if (we_log[i] !== 1'b0) errs++;
                if (wbe_log[i] !== 1'b0) errs++;
                if (addr_log[i] !== ((i <= 5) ? 18'd2 : 18'd3)) errs++;
                if (dq_log[i] !== ((i <= 5) ? 16'hBEEF : 16'hDEAD)) errs++;
            end
        end
        chk("st_sram_phases", errs, 32'd0);
        chk("st_wbe_pass", {31'b0, wb_enable_out}, 32'd1);
        chk("st_mrd", {31'b0, mem_read_out}, 32'd0);
        chk("st_dest", {28'b0, wb_dest_out}, 32'd5);

        mem_op(1'b1, 1'b0, 1'b1, 4'd7, 32'd1028, 32'd0, fc);
        chk("ld_freeze_cycles", fc, 32'd11);
        chk("ld_data", data_memory_out, 32'hDEAD_BEEF);
        chk("ld_mrd",  {31'b0, mem_read_out}, 32'd1);
        chk("ld_wbe",  {31'b0, wb_enable_out}, 32'd1);
        chk("ld_dest", {28'b0, wb_dest_out}, 32'd7);
        chk("ld_alu",  alu_result_out, 32'd1028);

        oe0 = oe_cnt;
        mem_op(1'b1, 1'b0, 1'b1, 4'd8, 32'd1028, 32'd0, fc);
`ifdef READ_BUFFER_EN
        chk("ld2_freeze_cycles", fc, 32'd0);
        chk("ld2_sram_reads", oe_cnt - oe0, 32'd0);
`else
        chk("ld2_freeze_cycles", fc, 32'd11);
        chk("ld2_sram_reads", oe_cnt - oe0, 32'd10);
`endif
        chk("ld2_data", data_memory_out, 32'hDEAD_BEEF);
        chk("ld2_mrd",  {31'b0, mem_read_out}, 32'd1);

        mem_op(1'b0, 1'b1, 1'b0, 4'd0, 32'd1028, 32'h1234_5678, fc);
        chk("st2_freeze_cycles", fc, 32'd11);
        oe0 = oe_cnt;
        mem_op(1'b1, 1'b0, 1'b1, 4'd2, 32'd1028, 32'd0, fc);
`ifdef READ_BUFFER_EN
        chk("ld3_freeze_cycles", fc, 32'd0);
        chk("ld3_sram_reads", oe_cnt - oe0, 32'd0);
`else
        chk("ld3_freeze_cycles", fc, 32'd11);
`endif
        chk("ld3_data", data_memory_out, 32'h1234_5678);

        mem_op(1'b1, 1'b1, 1'b1, 4'd4, 32'd1032, 32'hCAFE_F00D, fc);
        chk("rw_freeze_cycles", fc, 32'd11);
        chk("rw_mrd", {31'b0, mem_read_out}, 32'd0);
        mem_op(1'b1, 1'b0, 1'b1, 4'd6, 32'd1032, 32'd0, fc);
        chk("rw_ld_freeze", fc, 32'd11);
        chk("rw_ld_data", data_memory_out, 32'hCAFE_F00D);

        @(posedge clk); #1;
        mem_read_in   = 1'b1;
        wb_enable_in  = 1'b1;
        wb_dest_in    = 4'd9;
        alu_result_in = 32'd1036;
        repeat (8) @(negedge clk);
        chk("mid_hi_addr", {14'b0, sram_addr}, 32'd7);
        chk("mid_hi_oe",   {31'b0, sram_oe_n}, 32'd0);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("mid_rst_oe",   {31'b0, sram_oe_n}, 32'd1);
        chk("mid_rst_we",   {31'b0, sram_we_n}, 32'd1);
        chk("mid_rst_addr", {14'b0, sram_addr}, 32'd0);
        chk("mid_rst_frz",  {31'b0, freeze}, 32'd0);
        chk("mid_rst_data", data_memory_out, 32'd0);
        chk("mid_rst_misc", {wb_enable_out, mem_read_out, wb_dest_out, alu_result_out[25:0]}, 32'd0);
        rst = 1'b0;

        @(posedge clk); #1;
        wb_enable_in  = 1'b1;
        wb_dest_in    = 4'd3;
        alu_result_in = 32'h55;
        @(negedge clk);
        chk("post_rst_freeze", {31'b0, freeze}, 32'd0);
        @(negedge clk);
        chk("post_rst_wbe",  {31'b0, wb_enable_out}, 32'd1);
        chk("post_rst_alu",  alu_result_out, 32'h55);
        chk("post_rst_dest", {28'b0, wb_dest_out}, 32'd3);
        @(posedge clk); #1;
        idle_inputs();

        mem_op(1'b1, 1'b0, 1'b1, 4'd1, 32'd1032, 32'd0, fc);
        chk("after_rst_ld_freeze", fc, 32'd11);
        chk("after_rst_ld_data", data_memory_out, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
